// File: rtl/shift_reg_pkg.sv
// Shared encodings and FSM state type for the parametrised shift register.
package shift_reg_pkg;

    localparam logic [1:0] MODO_SHIFT = 2'b00;
    localparam logic [1:0] MODO_ROT   = 2'b01;
    localparam logic [1:0] MODO_LOAD  = 2'b10;
    localparam logic [1:0] MODO_HOLD  = 2'b11;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;

    typedef enum logic {IDLE, RUN} state_e;

    // Only shift and rotate move bits and can drive the serial output.
    function automatic logic is_step_mode(input logic [1:0] mode);
        return (mode == MODO_SHIFT) || (mode == MODO_ROT);
    endfunction

endpackage

// File: rtl/shift_reg_next.sv
// Combinational next-value logic: one shift/rotate/load/hold step.
module shift_reg_next
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [1:0]       mode_i,
    input  logic             dir_i,
    input  logic             s_in_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_next_o,
    output logic             bit_out_o
);

    logic in_bit;

    always_comb begin
        in_bit    = s_in_i;
        q_next_o  = q_i;
        bit_out_o = 1'b0;
        if (dir_i == DIR_RIGHT) begin
            bit_out_o = q_i[0];
            if (mode_i == MODO_ROT) in_bit = q_i[0];
        end else begin
            bit_out_o = q_i[WIDTH-1];
            if (mode_i == MODO_ROT) in_bit = q_i[WIDTH-1];
        end
        unique case (mode_i)
            MODO_SHIFT, MODO_ROT: begin
                if (dir_i == DIR_RIGHT) q_next_o = {in_bit, q_i[WIDTH-1:1]};
                else                    q_next_o = {q_i[WIDTH-2:0], in_bit};
            end
            MODO_LOAD: q_next_o = d_i;
            default:   q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/shift_reg_param.sv
// Universal shift register with single-step control and an autonomous burst engine.
module shift_reg_param
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STEP_W = $clog2(WIDTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enb_i,
    input  logic              dir_i,
    input  logic [1:0]        modo_i,
    input  logic              s_in_i,
    input  logic [WIDTH-1:0]  d_i,
    input  logic              start_i,
    input  logic [STEP_W-1:0] steps_i,
    output logic [WIDTH-1:0]  q_o,
    output logic              s_out_o,
    output logic              busy_o,
    output logic              done_o
);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   cnt_q, cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic                dir_q, dir_d;
    logic [WIDTH-1:0]    q_q, q_d;
    logic                s_out_q, s_out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [1:0]          step_mode;
    logic                step_dir;
    logic [WIDTH-1:0]    q_next;
    logic                bit_out;

    // During a burst the step logic sees only the controls latched at START.
    assign step_mode = (state_q == RUN) ? mode_q : modo_i;
    assign step_dir  = (state_q == RUN) ? dir_q  : dir_i;

    shift_reg_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q_i       (q_q),
        .mode_i    (step_mode),
        .dir_i     (step_dir),
        .s_in_i    (s_in_i),
        .d_i       (d_i),
        .q_next_o  (q_next),
        .bit_out_o (bit_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        q_d     = q_q;
        s_out_d = s_out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (is_step_mode(modo_i) && (steps_i != '0)) begin
                        state_d = RUN;
                        cnt_d   = steps_i;
                        mode_d  = modo_i;
                        dir_d   = dir_i;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (enb_i) begin
                    q_d = q_next;
                    if (is_step_mode(modo_i)) s_out_d = bit_out;
                end
            end
            RUN: begin
                if (enb_i) begin
                    q_d     = q_next;
                    s_out_d = bit_out;
                    cnt_d   = cnt_q - STEP_W'(1);
                    if (cnt_q == STEP_W'(1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= MODO_HOLD;
            dir_q   <= DIR_LEFT;
            q_q     <= '0;
            s_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            q_q     <= q_d;
            s_out_q <= s_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q_o     = q_q;
    assign s_out_o = s_out_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule
